// File: rtl/color_bounce_pkg.sv
// Shared types and constants for the color-bounce game sequencer and its helpers.
package color_bounce_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ERASE,
        S_MOVE,
        S_CHECK,
        S_DRAW,
        S_OVER
    } state_t;

    localparam logic [2:0] COLOR_BLACK = 3'b000;
    localparam logic [2:0] COLOR_WHITE = 3'b111;

    localparam int DEF_TOP   = 0;
    localparam int DEF_FLOOR = 100;
    localparam int DEF_STEP  = 4;
    localparam int DEF_POS_W = 8;

    localparam int PLAT_COLOR_W = 3;
    localparam int NUM_PLATS    = 4;

    // Platform i occupies bits [3i+2:3i] of the packed platform color word.
    function automatic logic [PLAT_COLOR_W-1:0] plat_color(
        input logic [PLAT_COLOR_W*NUM_PLATS-1:0] plats,
        input logic [1:0]                        idx
    );
        return plats[idx*PLAT_COLOR_W +: PLAT_COLOR_W];
    endfunction

endpackage

// File: rtl/ball_motion.sv
// Combinational one-frame ball step: next row, next direction and floor-hit flag.
module ball_motion
    import color_bounce_pkg::*;
#(
    parameter int TOP   = DEF_TOP,
    parameter int FLOOR = DEF_FLOOR,
    parameter int STEP  = DEF_STEP,
    parameter int POS_W = DEF_POS_W
) (
    input  logic [POS_W-1:0] curr_pos,
    input  logic             dir_up,
    output logic [POS_W-1:0] next_pos,
    output logic             next_dir_up,
    output logic             hit
);

    localparam logic [POS_W:0] TOP_X   = TOP[POS_W:0];
    localparam logic [POS_W:0] FLOOR_X = FLOOR[POS_W:0];
    localparam logic [POS_W:0] STEP_X  = STEP[POS_W:0];

    logic [POS_W:0] sum_down;
    logic [POS_W:0] up_limit;

    // Sums carry one extra bit so a step past the floor clamps instead of wrapping.
    always_comb begin
        sum_down    = {1'b0, curr_pos} + STEP_X;
        up_limit    = TOP_X + STEP_X;
        next_pos    = curr_pos;
        next_dir_up = dir_up;
        hit         = 1'b0;
        if (dir_up) begin
            if ({1'b0, curr_pos} <= up_limit) begin
                next_pos    = TOP_X[POS_W-1:0];
                next_dir_up = 1'b0;
            end else begin
                next_pos = curr_pos - STEP_X[POS_W-1:0];
            end
        end else begin
            if (sum_down >= FLOOR_X) begin
                next_pos = FLOOR_X[POS_W-1:0];
                hit      = 1'b1;
            end else begin
                next_pos = sum_down[POS_W-1:0];
            end
        end
    end

endmodule

// File: rtl/bounce_frame_ctrl.sv
// Per-frame game sequencer: erase, move, platform check and redraw of the ball,
// handshaking with the draw unit and strobing the game-state memory.
module bounce_frame_ctrl
    import color_bounce_pkg::*;
#(
    parameter int TOP   = DEF_TOP,
    parameter int FLOOR = DEF_FLOOR,
    parameter int STEP  = DEF_STEP,
    parameter int POS_W = DEF_POS_W
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                frame_tick,
    input  logic [2:0]                          color_sel,
    input  logic [PLAT_COLOR_W*NUM_PLATS-1:0]   color_plats,
    input  logic                                draw_ack,
    output logic                                draw_req,
    output logic                                draw_erase,
    output logic [POS_W-1:0]                    draw_pos,
    output logic [2:0]                          draw_color,
    output logic [POS_W-1:0]                    prev_ball,
    output logic [POS_W-1:0]                    curr_ball,
    output logic [2:0]                          color_ball,
    output logic [15:0]                         score,
    output logic [1:0]                          plat_idx,
    output logic                                mem_we,
    output logic                                game_over,
    output logic                                overrun
);

    localparam logic [POS_W-1:0] TOP_POS = TOP[POS_W-1:0];

    state_t           state_q, state_d;
    logic [POS_W-1:0] prev_ball_q, prev_ball_d;
    logic [POS_W-1:0] curr_ball_q, curr_ball_d;
    logic [2:0]       color_ball_q, color_ball_d;
    logic [15:0]      score_q, score_d;
    logic [1:0]       plat_idx_q, plat_idx_d;
    logic             dir_up_q, dir_up_d;
    logic             hit_q, hit_d;
    logic             mem_we_q, mem_we_d;
    logic             game_over_q, game_over_d;
    logic             overrun_q, overrun_d;

    logic [POS_W-1:0] mv_pos;
    logic             mv_dir_up;
    logic             mv_hit;
    logic             start_ok;
    logic             plat_match;

    ball_motion #(
        .TOP   (TOP),
        .FLOOR (FLOOR),
        .STEP  (STEP),
        .POS_W (POS_W)
    ) u_motion (
        .curr_pos    (curr_ball_q),
        .dir_up      (dir_up_q),
        .next_pos    (mv_pos),
        .next_dir_up (mv_dir_up),
        .hit         (mv_hit)
    );

    always_comb begin
        state_d      = state_q;
        prev_ball_d  = prev_ball_q;
        curr_ball_d  = curr_ball_q;
        color_ball_d = color_ball_q;
        score_d      = score_q;
        plat_idx_d   = plat_idx_q;
        dir_up_d     = dir_up_q;
        hit_d        = hit_q;
        mem_we_d     = 1'b0;
        game_over_d  = game_over_q;
        overrun_d    = overrun_q;
        draw_req     = 1'b0;
        draw_erase   = 1'b0;
        draw_pos     = '0;
        draw_color   = COLOR_BLACK;

        start_ok   = start && (state_q == S_IDLE || state_q == S_OVER);
        plat_match = (color_ball_q == plat_color(color_plats, plat_idx_q));

        // A tick that cannot start a frame is lost; a simultaneous start takes precedence.
        if (frame_tick && state_q != S_WAIT && !start_ok) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d      = S_WAIT;
                    prev_ball_d  = TOP_POS;
                    curr_ball_d  = TOP_POS;
                    color_ball_d = COLOR_WHITE;
                    score_d      = '0;
                    plat_idx_d   = '0;
                    dir_up_d     = 1'b0;
                    game_over_d  = 1'b0;
                    overrun_d    = 1'b0;
                end
            end
            S_WAIT: begin
                if (frame_tick) begin
                    state_d = S_ERASE;
                end
            end
            S_ERASE: begin
                draw_req   = 1'b1;
                draw_erase = 1'b1;
                draw_pos   = curr_ball_q;
                if (draw_ack) begin
                    state_d = S_MOVE;
                end
            end
            S_MOVE: begin
                prev_ball_d  = curr_ball_q;
                color_ball_d = color_sel;
                curr_ball_d  = mv_pos;
                dir_up_d     = mv_dir_up;
                hit_d        = mv_hit;
                state_d      = S_CHECK;
            end
            S_CHECK: begin
                hit_d = 1'b0;
                if (!hit_q) begin
                    state_d = S_DRAW;
                end else if (plat_match) begin
                    if (score_q != 16'hFFFF) begin
                        score_d = score_q + 16'd1;
                    end
                    plat_idx_d = plat_idx_q + 2'd1;
                    dir_up_d   = 1'b1;
                    state_d    = S_DRAW;
                end else begin
                    // Miss: the ball stays erased and memory captures the final state.
                    mem_we_d    = 1'b1;
                    game_over_d = 1'b1;
                    state_d     = S_OVER;
                end
            end
            S_DRAW: begin
                draw_req   = 1'b1;
                draw_pos   = curr_ball_q;
                draw_color = color_ball_q;
                if (draw_ack) begin
                    mem_we_d = 1'b1;
                    state_d  = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            prev_ball_q  <= TOP_POS;
            curr_ball_q  <= TOP_POS;
            color_ball_q <= COLOR_WHITE;
            score_q      <= '0;
            plat_idx_q   <= '0;
            dir_up_q     <= 1'b0;
            hit_q        <= 1'b0;
            mem_we_q     <= 1'b0;
            game_over_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_ball_q  <= prev_ball_d;
            curr_ball_q  <= curr_ball_d;
            color_ball_q <= color_ball_d;
            score_q      <= score_d;
            plat_idx_q   <= plat_idx_d;
            dir_up_q     <= dir_up_d;
            hit_q        <= hit_d;
            mem_we_q     <= mem_we_d;
            game_over_q  <= game_over_d;
            overrun_q    <= overrun_d;
        end
    end

    assign prev_ball  = prev_ball_q;
    assign curr_ball  = curr_ball_q;
    assign color_ball = color_ball_q;
    assign score      = score_q;
    assign plat_idx   = plat_idx_q;
    assign mem_we     = mem_we_q;
    assign game_over  = game_over_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_bounce_frame_ctrl.sv
// Directed self-checking bench for bounce_frame_ctrl: full bounce cycles, miss, restart,
// handshake stalls, overrun, score saturation and asynchronous reset.
module tb_bounce_frame_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        frame_tick;
    logic [2:0]  color_sel;
    logic [11:0] color_plats;
    logic        draw_ack;
    logic        draw_req;
    logic        draw_erase;
    logic [7:0]  draw_pos;
    logic [2:0]  draw_color;
    logic [7:0]  prev_ball;
    logic [7:0]  curr_ball;
    logic [2:0]  color_ball;
    logic [15:0] score;
    logic [1:0]  plat_idx;
    logic        mem_we;
    logic        game_over;
    logic        overrun;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  exp_cur;

    always #5 clk = ~clk;

    bounce_frame_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .frame_tick  (frame_tick),
        .color_sel   (color_sel),
        .color_plats (color_plats),
        .draw_ack    (draw_ack),
        .draw_req    (draw_req),
        .draw_erase  (draw_erase),
        .draw_pos    (draw_pos),
        .draw_color  (draw_color),
        .prev_ball   (prev_ball),
        .curr_ball   (curr_ball),
        .color_ball  (color_ball),
        .score       (score),
        .plat_idx    (plat_idx),
        .mem_we      (mem_we),
        .game_over   (game_over),
        .overrun     (overrun)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame from tick to return to waiting; exp_cur tracks the row before the move.
    task automatic applyStimulus(input logic [2:0] csel, input int erase_wait,
                                 input bit tick_in_draw, input bit expect_over,
                                 input logic [7:0] new_pos);
        color_sel  = csel;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        checkOutput("erase_req", 16'(draw_req), 16'd1);
        checkOutput("erase_flag", 16'(draw_erase), 16'd1);
        checkOutput("erase_pos", 16'(draw_pos), 16'(exp_cur));
        for (int i = 0; i < erase_wait; i++) begin
            step();
            checkOutput("erase_hold_req", 16'(draw_req), 16'd1);
            checkOutput("erase_hold_flag", 16'(draw_erase), 16'd1);
            checkOutput("erase_hold_pos", 16'(draw_pos), 16'(exp_cur));
        end
        draw_ack = 1'b1;
        step();
        draw_ack = 1'b0;
        checkOutput("erase_req_drop", 16'(draw_req), 16'd0);
        step();
        step();
        if (expect_over) begin
            checkOutput("over_no_draw", 16'(draw_req), 16'd0);
            checkOutput("over_flag", 16'(game_over), 16'd1);
            checkOutput("over_we", 16'(mem_we), 16'd1);
            checkOutput("over_curr", 16'(curr_ball), 16'(new_pos));
            checkOutput("over_prev", 16'(prev_ball), 16'(exp_cur));
            step();
            checkOutput("over_we_pulse", 16'(mem_we), 16'd0);
            checkOutput("over_still_no_draw", 16'(draw_req), 16'd0);
        end else begin
            checkOutput("draw_req", 16'(draw_req), 16'd1);
            checkOutput("draw_flag", 16'(draw_erase), 16'd0);
            checkOutput("draw_pos", 16'(draw_pos), 16'(new_pos));
            checkOutput("draw_color", 16'(draw_color), 16'(csel));
            checkOutput("draw_we_early", 16'(mem_we), 16'd0);
            if (tick_in_draw) begin
                frame_tick = 1'b1;
                step();
                frame_tick = 1'b0;
                checkOutput("overrun_set", 16'(overrun), 16'd1);
                checkOutput("draw_hold_req", 16'(draw_req), 16'd1);
                checkOutput("draw_hold_we", 16'(mem_we), 16'd0);
            end
            draw_ack = 1'b1;
            step();
            draw_ack = 1'b0;
            checkOutput("frame_we", 16'(mem_we), 16'd1);
            checkOutput("frame_curr", 16'(curr_ball), 16'(new_pos));
            checkOutput("frame_prev", 16'(prev_ball), 16'(exp_cur));
            step();
            checkOutput("frame_we_pulse", 16'(mem_we), 16'd0);
            checkOutput("frame_req_idle", 16'(draw_req), 16'd0);
        end
        exp_cur = new_pos;
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        frame_tick  = 1'b0;
        draw_ack    = 1'b0;
        color_sel   = 3'b000;
        color_plats = 12'b011_100_010_001;
        exp_cur     = 8'd0;
        step();
        step();

        checkOutput("rst_curr", 16'(curr_ball), 16'd0);
        checkOutput("rst_prev", 16'(prev_ball), 16'd0);
        checkOutput("rst_color", 16'(color_ball), 16'd7);
        checkOutput("rst_score", score, 16'd0);
        checkOutput("rst_plat", 16'(plat_idx), 16'd0);
        checkOutput("rst_req", 16'(draw_req), 16'd0);
        checkOutput("rst_erase", 16'(draw_erase), 16'd0);
        checkOutput("rst_pos", 16'(draw_pos), 16'd0);
        checkOutput("rst_dcolor", 16'(draw_color), 16'd0);
        checkOutput("rst_we", 16'(mem_we), 16'd0);
        checkOutput("rst_over", 16'(game_over), 16'd0);
        checkOutput("rst_overrun", 16'(overrun), 16'd0);

        reset = 1'b0;
        step();
        start      = 1'b1;
        frame_tick = 1'b1;
        step();
        start      = 1'b0;
        frame_tick = 1'b0;
        checkOutput("start_beats_tick", 16'(overrun), 16'd0);
        checkOutput("start_no_req", 16'(draw_req), 16'd0);

        $display("[TB] descending to first platform");
        for (int k = 1; k <= 25; k++) begin
            applyStimulus(3'b001, 0, 1'b0, 1'b0, 8'(4 * k));
        end
        checkOutput("hit1_score", score, 16'd1);
        checkOutput("hit1_plat", 16'(plat_idx), 16'd1);
        checkOutput("hit1_overrun", 16'(overrun), 16'd0);

        $display("[TB] rising with stalled ack and overrun");
        for (int k = 1; k <= 25; k++) begin
            applyStimulus(3'b010, (k == 3) ? 10 : 0, (k == 6), 1'b0, 8'(100 - 4 * k));
        end
        checkOutput("overrun_sticky", 16'(overrun), 16'd1);
        checkOutput("rise_score", score, 16'd1);

        $display("[TB] descending to a missed platform");
        for (int k = 1; k <= 24; k++) begin
            applyStimulus(3'b010, 0, 1'b0, 1'b0, 8'(4 * k));
        end
        applyStimulus(3'b101, 0, 1'b0, 1'b1, 8'd100);
        checkOutput("miss_score", score, 16'd1);
        checkOutput("miss_plat", 16'(plat_idx), 16'd1);
        checkOutput("miss_color", 16'(color_ball), 16'd5);
        checkOutput("miss_overrun", 16'(overrun), 16'd1);
        step();
        checkOutput("over_hold", 16'(game_over), 16'd1);

        start = 1'b1;
        step();
        start = 1'b0;
        checkOutput("restart_curr", 16'(curr_ball), 16'd0);
        checkOutput("restart_prev", 16'(prev_ball), 16'd0);
        checkOutput("restart_score", score, 16'd0);
        checkOutput("restart_plat", 16'(plat_idx), 16'd0);
        checkOutput("restart_over", 16'(game_over), 16'd0);
        checkOutput("restart_overrun", 16'(overrun), 16'd0);
        checkOutput("restart_color", 16'(color_ball), 16'd7);
        exp_cur = 8'd0;

        $display("[TB] saturating score at the last platform");
        for (int k = 1; k <= 24; k++) begin
            applyStimulus(3'b011, 0, 1'b0, 1'b0, 8'(4 * k));
        end
        force dut.score_q    = 16'hFFFF;
        force dut.plat_idx_q = 2'd3;
        #1;
        release dut.score_q;
        release dut.plat_idx_q;
        step();
        checkOutput("preset_score", score, 16'hFFFF);
        checkOutput("preset_plat", 16'(plat_idx), 16'd3);
        applyStimulus(3'b011, 0, 1'b0, 1'b0, 8'd100);
        checkOutput("sat_score", score, 16'hFFFF);
        checkOutput("sat_plat_wrap", 16'(plat_idx), 16'd0);

        $display("[TB] asynchronous reset during erase");
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        checkOutput("pre_rst_req", 16'(draw_req), 16'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_rst_req", 16'(draw_req), 16'd0);
        checkOutput("async_rst_curr", 16'(curr_ball), 16'd0);
        checkOutput("async_rst_color", 16'(color_ball), 16'd7);
        checkOutput("async_rst_score", score, 16'd0);
        checkOutput("async_rst_plat", 16'(plat_idx), 16'd0);
        step();
        reset      = 1'b0;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        checkOutput("idle_tick_overrun", 16'(overrun), 16'd1);
        checkOutput("idle_tick_no_req", 16'(draw_req), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bounce_frame_ctrl.md
Name: bounce_frame_ctrl

Overview:
Per-frame game sequencer for the color-bounce datapath. It owns ball position, direction, ball color, score and the active-platform index. It runs one erase/move/check/draw cycle per frame tick, handshaking with the VGA draw unit. It pulses a write-enable so the game-state memory latches the new prev/curr ball, ball color and score.

Parameters:
TOP, 0, topmost ball row (bounce point going up)
FLOOR, 100, platform row (bounce/check point going down)
STEP, 4, rows moved per frame
POS_W, 8, ball position width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: begin/restart game
frame_tick  in  1  one-cycle pulse per video frame
color_sel  in  3  player-selected ball color
color_plats  in  12  platform colors, platform i = bits [3i+2:3i]
draw_ack  in  1  draw unit accepted request
draw_req  out  1  draw request, held until ack
draw_erase  out  1  1 = erase at draw_pos, 0 = paint
draw_pos  out  8  row to erase/paint
draw_color  out  3  paint color
prev_ball  out  8  ball row before this frame's move
curr_ball  out  8  ball row after move
color_ball  out  3  current ball color
score  out  16  bounce count
plat_idx  out  2  platform checked at next floor hit
mem_we  out  1  one-cycle pulse: memory latches outputs
game_over  out  1  high in S_OVER
overrun  out  1  sticky: frame_tick arrived outside S_WAIT

Behaviour:
- Reset (async, immediate): state S_IDLE; prev_ball = curr_ball = TOP; color_ball = 3'b111; score = 0; plat_idx = 0; dir = down; draw_req = 0, draw_erase = 0, draw_pos = 0, draw_color = 0; mem_we = 0; game_over = 0; overrun = 0.
- Reset mid-frame abandons any outstanding draw_req with no completion.
- S_IDLE: on start, go to S_WAIT.
- S_WAIT: on frame_tick, go to S_ERASE.
- S_ERASE: draw_req = 1, draw_erase = 1, draw_pos = curr_ball. Request fields stay stable until draw_ack. Ack is legal in the first req cycle. draw_req drops the cycle after ack; the FSM then goes to S_MOVE.
- S_MOVE (1 cycle): prev_ball <= curr_ball; color_ball <= color_sel.
  - Moving down: if curr_ball + STEP >= FLOOR, curr_ball <= FLOOR and the internal hit flag is set. Otherwise curr_ball += STEP. Compute the sum at POS_W+1 bits; no wrap.
  - Moving up: if curr_ball <= TOP + STEP, curr_ball <= TOP and dir <= down. Otherwise curr_ball -= STEP.
- S_CHECK (1 cycle):
  - Hit flag clear: go to S_DRAW.
  - Hit, color_ball == platform[plat_idx]: score += 1, saturating at 16'hFFFF; plat_idx += 1 mod 4; dir <= up; go to S_DRAW.
  - Hit, mismatch: mem_we pulses; game_over <= 1; go to S_OVER. The ball is left erased.
  - The hit flag clears on leaving S_CHECK.
- S_DRAW: draw_req = 1, draw_erase = 0, draw_pos = curr_ball, draw_color = color_ball. Same handshake as S_ERASE. On ack: mem_we pulses the following cycle and the FSM goes to S_WAIT.
- S_OVER: outputs hold. On start: curr_ball = prev_ball = TOP, score = 0, plat_idx = 0, dir = down, game_over = 0, color_ball = 3'b111; go to S_WAIT.
- frame_tick in any state other than S_WAIT is dropped and sets overrun. overrun clears only on reset or start.
- start outside S_IDLE/S_OVER is ignored.
- Simultaneous start and frame_tick in S_IDLE: start wins; the tick is dropped without setting overrun.
- Minimum frame latency, tick to mem_we: ERASE(1) + MOVE + CHECK + DRAW(1) + 1 = 5 cycles with immediate acks.

Decomposition:
- Package color_bounce_pkg:
  - state enum (S_IDLE, S_WAIT, S_ERASE, S_MOVE, S_CHECK, S_DRAW, S_OVER);
  - color constants (COLOR_WHITE = 3'b111, etc.);
  - default TOP/FLOOR/STEP;
  - PLAT_COLOR_W = 3, NUM_PLATS = 4.
- One sub-module, ball_motion: combinational next position, next direction and hit flag from curr_ball, dir, TOP, FLOOR, STEP. It is reused by the sim model.

Test Plan:
- Reset mid-S_ERASE with draw_req high -> draw_req = 0 immediately; curr_ball = 0, color_ball = 7, score = 0, state S_IDLE.
- start, then 25 ticks with immediate acks and color_sel = platform[0] color -> curr_ball steps 4, 8 … 100. The 25th frame scores: score = 1, plat_idx = 1, dir up. mem_we arrives 5 cycles after each tick.
- At floor with color_sel != platform[plat_idx] -> no S_DRAW request; game_over = 1, score unchanged. A following start gives curr_ball = 0, score = 0, game_over = 0.
- draw_ack delayed 10 cycles in S_ERASE -> draw_req, draw_erase = 1 and draw_pos stay stable for all 10 cycles; the req drops the cycle after ack.
- frame_tick pulsed during S_DRAW -> tick dropped, overrun = 1 and sticky until start. Exactly one mem_we for that frame.
- Score preset path: force 16'hFFFF, then a matching hit -> score stays FFFF and plat_idx wraps 3 -> 0.
